// File: rtl/riscv_bus_pkg.sv
// Shared bus definitions: arbiter FSM states and requester port indices.
package riscv_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;  // CPU load/store
    localparam logic PORT1 = 1'b1;  // I2C bridge

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin tie-break: picks the sole requester, or on a tie the port not served last.
module rr_pick2
    import riscv_bus_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    assign winner = (req0 && req1) ? (last == PORT0) : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with lockable bursts capped at MAX_BURST while the other port waits.
// Grants are decoded from the registered ownership state, so a dropped request is never issued.
module dmem_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q;
    logic             rv0_q, rv1_q;
    logic             winner;
    logic             at_cap;
    logic             own_req, own_lock, oth_req;
    arb_state_e       oth_st;

    rr_pick2 u_rr_pick2 (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .winner (winner)
    );

    assign at_cap = (cnt_q == CNT_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        own_req  = 1'b0;
        own_lock = 1'b0;
        oth_req  = 1'b0;
        oth_st   = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) state_d = (winner == PORT1) ? ST_OWN1 : ST_OWN0;
            end
            ST_OWN0: begin
                own_req  = req0;
                own_lock = lock0;
                oth_req  = req1;
                oth_st   = ST_OWN1;
            end
            ST_OWN1: begin
                own_req  = req1;
                own_lock = lock1;
                oth_req  = req0;
                oth_st   = ST_OWN0;
            end
            default: state_d = ST_IDLE;
        endcase

        // A waiting port only preempts an unlocked owner or one that hit the burst cap;
        // with no contender the count parks at the cap instead of wrapping.
        if (state_q == ST_OWN0 || state_q == ST_OWN1) begin
            if (!own_req || (oth_req && (!own_lock || at_cap)))
                state_d = oth_req ? oth_st : ST_IDLE;
            else if (!at_cap)
                cnt_d = cnt_q + 1'b1;
        end

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= PORT1;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (gnt0)      last_q <= PORT0;
            else if (gnt1) last_q <= PORT1;
            // Strobe follows the issuing port even if ownership moves on next cycle.
            rv0_q   <= gnt0 && !we0;
            rv1_q   <= gnt1 && !we1;
        end
    end

    assign gnt0 = (state_q == ST_OWN0) && req0;
    assign gnt1 = (state_q == ST_OWN1) && req1;

    assign mem_we    = gnt0 ? we0    : (gnt1 ? we1    : 1'b0);
    assign mem_addr  = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
    assign mem_wdata = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

    assign rvalid0 = rv0_q;
    assign rvalid1 = rv1_q;
    assign rdata0  = rv0_q ? mem_rdata : '0;
    assign rdata1  = rv1_q ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: port drivers hold commands until granted, a monitor checks grants and read strobes.
module tb_dmem_arbiter;

    localparam logic [31:0] KEY = 32'h5A5A_0000;

    typedef struct { logic lock; logic we; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
    typedef struct { int port; logic we; logic [31:0] addr; logic [31:0] wdata; int lat; } exp_g_t;
    typedef struct { int port; logic [31:0] data; } exp_r_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    cmd_t   cq0[$], cq1[$];
    exp_g_t exp_g[$];
    exp_r_t exp_r[$];
    int     n_cmp = 0, n_bad = 0;
    int     cyc = 0, pres0 = 0, pres1 = 0, gnt_seen0 = 0, gnt_seen1 = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Memory stand-in: read data is a fixed function of the address, one cycle later.
    always @(posedge clk) mem_rdata <= mem_addr ^ KEY;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input int p, input logic lk, input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_t c;
        c.lock = lk; c.we = w; c.addr = a; c.wdata = d;
        if (p == 0) cq0.push_back(c); else cq1.push_back(c);
    endtask

    // Expected grant in arbitration order; reads also expect their strobe in the same order.
    task automatic expect_g(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                            input int lat, input bit want_rv);
        exp_g_t e;
        exp_r_t r;
        e.port = p; e.we = w; e.addr = a; e.wdata = d; e.lat = lat;
        exp_g.push_back(e);
        if (!w && want_rv) begin
            r.port = p; r.data = a ^ KEY;
            exp_r.push_back(r);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_g.size() + exp_r.size() + cq0.size() + cq1.size()) != 0 && t < 200) begin
            step(1);
            t++;
        end
        chk("drain_in_time", t < 200, 1);
        step(3);
    endtask

    initial begin : drv0
        logic g;
        cmd_t c;
        req0 = 0; lock0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        forever begin
            @(negedge clk); g = gnt0;
            @(posedge clk); #2;
            if (g && cq0.size() > 0) void'(cq0.pop_front());
            if (cq0.size() > 0) begin
                if (g || !req0) pres0 = cyc;
                c = cq0[0];
                req0 = 1; lock0 = c.lock; we0 = c.we; addr0 = c.addr; wdata0 = c.wdata;
            end else begin
                req0 = 0; lock0 = 0; we0 = 0;
            end
        end
    end

    initial begin : drv1
        logic g;
        cmd_t c;
        req1 = 0; lock1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        forever begin
            @(negedge clk); g = gnt1;
            @(posedge clk); #2;
            if (g && cq1.size() > 0) void'(cq1.pop_front());
            if (cq1.size() > 0) begin
                if (g || !req1) pres1 = cyc;
                c = cq1[0];
                req1 = 1; lock1 = c.lock; we1 = c.we; addr1 = c.addr; wdata1 = c.wdata;
            end else begin
                req1 = 0; lock1 = 0; we1 = 0;
            end
        end
    end

    initial begin : mon
        exp_g_t e;
        exp_r_t r;
        int p;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (gnt0 || gnt1) begin
                    p = gnt1 ? 1 : 0;
                    chk("gnt_onehot", {63'd0, gnt0 & gnt1}, 0);
                    if (exp_g.size() == 0) chk("gnt_unexpected", 1, 0);
                    else begin
                        e = exp_g.pop_front();
                        chk("gnt_port", p, e.port);
                        chk("gnt_we_addr", {31'd0, mem_we, mem_addr}, {31'd0, e.we, e.addr});
                        if (e.we) chk("gnt_wdata", mem_wdata, e.wdata);
                        if (e.lat >= 0) chk("gnt_latency", (p == 1) ? cyc - pres1 : cyc - pres0, e.lat);
                    end
                    if (p == 1) gnt_seen1++; else gnt_seen0++;
                end else begin
                    chk("idle_mem_we", mem_we, 0);
                end
                if (rvalid0 || rvalid1) begin
                    p = rvalid1 ? 1 : 0;
                    chk("rv_onehot", {63'd0, rvalid0 & rvalid1}, 0);
                    if (exp_r.size() == 0) chk("rv_unexpected", 1, 0);
                    else begin
                        r = exp_r.pop_front();
                        chk("rv_port", p, r.port);
                        chk("rv_data", (p == 1) ? rdata1 : rdata0, r.data);
                    end
                end
            end
        end
    end

    initial begin : stim
        int t;
        // Reset state
        step(3);
        @(negedge clk);
        chk("reset_outputs", {gnt0, gnt1, rvalid0, rvalid1, mem_we}, 0);
        reset = 1;
        step(2);

        // First tie after reset goes to port 0, then port 1; the next tie again to port 0
        send(0, 0, 0, 32'h08, 0); send(1, 0, 0, 32'h40, 0);
        expect_g(0, 0, 32'h08, 0, 1, 1); expect_g(1, 0, 32'h40, 0, 2, 1);
        drain();
        send(0, 0, 0, 32'h0C, 0); send(1, 0, 0, 32'h44, 0);
        expect_g(0, 0, 32'h0C, 0, 1, 1); expect_g(1, 0, 32'h44, 0, 2, 1);
        drain();

        // Port 1 write: data on the memory side, no strobe
        send(1, 0, 1, 32'h20, 32'hA5A5);
        expect_g(1, 1, 32'h20, 32'hA5A5, 1, 1);
        drain();

        // Port 0 lone read at 0x10
        send(0, 0, 0, 32'h10, 0);
        expect_g(0, 0, 32'h10, 0, 1, 1);
        drain();

        // Tie with port 0 served last: port 1 wins
        send(0, 0, 0, 32'h50, 0); send(1, 0, 0, 32'h60, 0);
        expect_g(1, 0, 32'h60, 0, 1, 1); expect_g(0, 0, 32'h50, 0, 2, 1);
        drain();
        send(1, 0, 0, 32'h70, 0);
        expect_g(1, 0, 32'h70, 0, 1, 1);
        drain();

        // Locked burst with port 1 waiting: four port-0 transfers, then port 1, then port 0 resumes
        for (int i = 0; i < 6; i++) send(0, 1, 0, 32'h80 + 32'(4 * i), 0);
        send(1, 0, 0, 32'h100, 0);
        expect_g(0, 0, 32'h80, 0, 1, 1); expect_g(0, 0, 32'h84, 0, 0, 1);
        expect_g(0, 0, 32'h88, 0, 0, 1); expect_g(0, 0, 32'h8C, 0, 0, 1);
        expect_g(1, 0, 32'h100, 0, 5, 1);
        expect_g(0, 0, 32'h90, 0, 1, 1); expect_g(0, 0, 32'h94, 0, 0, 1);
        drain();

        // Locked burst alone saturates the count; a late port-1 request preempts at once
        for (int i = 0; i < 8; i++) send(0, 1, 0, 32'hA0 + 32'(4 * i), 0);
        expect_g(0, 0, 32'hA0, 0, 1, 1);
        for (int i = 1; i < 6; i++) expect_g(0, 0, 32'hA0 + 32'(4 * i), 0, 0, 1);
        t = gnt_seen0 + 5;
        for (int k = 0; k < 50 && gnt_seen0 < t; k++) step(1);
        chk("burst_progress", gnt_seen0, t);
        send(1, 0, 0, 32'hC0, 0);
        expect_g(1, 0, 32'hC0, 0, 1, 1);
        expect_g(0, 0, 32'hB8, 0, 1, 1); expect_g(0, 0, 32'hBC, 0, 0, 1);
        drain();

        // Reset while port 1 owns the bus with a read in flight
        send(1, 0, 0, 32'h200, 0);
        expect_g(1, 0, 32'h200, 0, 1, 0);
        t = 0;
        do begin @(negedge clk); #1; t++; end while (!gnt1 && t < 50);
        chk("reach_own1", t < 50, 1);
        reset = 0;
        cq1.delete();
        #1;
        chk("reset_mid_outputs", {gnt0, gnt1, rvalid0, rvalid1, mem_we}, 0);
        step(2);
        @(negedge clk); reset = 1;
        step(6);

        // Reset restores last-served = port 1, so port 0 wins the next tie
        send(0, 0, 0, 32'h300, 0);
        expect_g(0, 0, 32'h300, 0, 1, 1);
        drain();
        @(negedge clk); reset = 0;
        step(2);
        @(negedge clk); reset = 1;
        step(2);
        send(0, 0, 0, 32'h310, 0); send(1, 0, 0, 32'h320, 0);
        expect_g(0, 0, 32'h310, 0, 1, 1); expect_g(1, 0, 32'h320, 0, 2, 1);
        drain();

        chk("scoreboard_empty", exp_g.size() + exp_r.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
